// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, FSM encoding and helpers for the TDM FIR sequencer
package fir_pkg;
    typedef shortint sample_t;
    typedef shortint coef_t;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

    function automatic int acc_width(input int num_taps);
        return 32 + $clog2(num_taps);
    endfunction

    // Tap 0 at 1<<SHIFT cancels the output shift, so a freshly reset filter is a pass-through.
    function automatic coef_t unity_coef(input int shift);
        return coef_t'(1 << shift);
    endfunction
endpackage

// File: rtl/fir_delay_ram.sv
// rtl/fir_delay_ram.sv - per-channel circular sample history, one write port and one combinational read port
module fir_delay_ram
    import fir_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int NUM_TAPS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_we,
    input  logic [$clog2(NUM_CH)-1:0]   i_wch,
    input  logic [15:0]                 i_wdata,
    input  logic                        i_adv,
    input  logic [$clog2(NUM_CH)-1:0]   i_rch,
    input  logic [$clog2(NUM_TAPS)-1:0] i_rtap,
    output logic [15:0]                 o_rdata
);
    localparam int TAP_W = $clog2(NUM_TAPS);

    sample_t          r_mem  [NUM_CH][NUM_TAPS];
    logic [TAP_W-1:0] r_wptr [NUM_CH];
    logic [TAP_W-1:0] w_rptr;
    logic [TAP_W-1:0] w_ridx;

    assign w_rptr = r_wptr[i_rch];

    // Tap k reads (wptr - k) mod NUM_TAPS; wptr still points at the newest sample during MAC.
    always_comb begin
        if (w_rptr >= i_rtap) begin
            w_ridx = w_rptr - i_rtap;
        end else begin
            w_ridx = w_rptr + TAP_W'(NUM_TAPS) - i_rtap;
        end
    end

    assign o_rdata = r_mem[i_rch][w_ridx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_mem[c][t] <= '0;
                end
                r_wptr[c] <= '0;
            end
        end else begin
            if (i_we) begin
                r_mem[i_wch][r_wptr[i_wch]] <= sample_t'(i_wdata);
            end
            if (i_adv) begin
                r_wptr[i_wch] <= (r_wptr[i_wch] == TAP_W'(NUM_TAPS - 1)) ? '0
                                                                         : r_wptr[i_wch] + TAP_W'(1);
            end
        end
    end
endmodule

// File: rtl/fir_tdm_sequencer.sv
// rtl/fir_tdm_sequencer.sv - TDM FIR controller sharing one 16x16 MAC across channels; FIR_SAT_EN selects saturating output
module fir_tdm_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int NUM_TAPS = 5,
    parameter int SHIFT    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(NUM_CH)-1:0]   in_ch,
    input  logic [15:0]                 in_sample,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic [15:0]                 out_sample,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [15:0]                 coef_data,
    output logic                        coef_ready
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int ACC_W = acc_width(NUM_TAPS);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CH_W-1:0]         r_ch;
    sample_t                 r_sample;
    logic [TAP_W-1:0]        r_tap;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;
    coef_t                   r_coef [NUM_TAPS];
    logic                    r_out_valid;
    logic [CH_W-1:0]         r_out_ch;
    logic [15:0]             r_out_sample;

    logic                    w_accept;
    logic                    w_coef_wr;
    logic                    w_ram_we;
    logic                    w_mac_last;
    logic                    w_out_hs;
    logic                    w_ch_ok;
    logic                    w_addr_ok;
    logic [15:0]             w_ram_rdata;
    logic signed [15:0]      w_x;
    logic signed [15:0]      w_c;
    logic signed [31:0]      w_prod;
    logic [15:0]             w_result;

    assign w_ch_ok   = 32'(in_ch) < NUM_CH;
    assign w_addr_ok = 32'(coef_addr) < NUM_TAPS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready outputs are masked by rst so every output reads 0 while reset is held.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        coef_ready   = 1'b0;
        w_accept     = 1'b0;
        w_coef_wr    = 1'b0;
        w_ram_we     = 1'b0;
        w_mac_last   = 1'b0;
        w_out_hs     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready   = !rst && !coef_we;
                coef_ready = !rst;
                if (coef_we) begin
                    w_coef_wr = 1'b1;
                end else if (in_valid && w_ch_ok) begin
                    w_accept     = 1'b1;
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_ram_we     = 1'b1;
                w_next_state = MAC;
            end
            MAC: begin
                if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
                    w_mac_last   = 1'b1;
                    w_next_state = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_out_hs     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    fir_delay_ram #(
        .NUM_CH  (NUM_CH),
        .NUM_TAPS(NUM_TAPS)
    ) u_delay_ram (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_ram_we),
        .i_wch  (r_ch),
        .i_wdata(r_sample),
        .i_adv  (w_mac_last),
        .i_rch  (r_ch),
        .i_rtap (r_tap),
        .o_rdata(w_ram_rdata)
    );

    assign w_x        = w_ram_rdata;
    assign w_c        = r_coef[r_tap];
    assign w_prod     = 32'(w_x) * 32'(w_c);
    assign w_acc_next = r_acc + ACC_W'(w_prod);

    // The output is formed from w_acc_next so it registers on the same edge as the last tap.
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = w_acc_next >>> SHIFT;

    always_comb begin
        if (w_shifted > SAT_MAX) begin
            w_result = 16'h7fff;
        end else if (w_shifted < SAT_MIN) begin
            w_result = 16'h8000;
        end else begin
            w_result = w_shifted[15:0];
        end
    end
`else
    assign w_result = w_acc_next[SHIFT +: 16];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch         <= '0;
            r_sample     <= '0;
            r_tap        <= '0;
            r_acc        <= '0;
            r_coef[0]    <= unity_coef(SHIFT);
            for (int k = 1; k < NUM_TAPS; k++) begin
                r_coef[k] <= '0;
            end
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_sample <= '0;
        end else begin
            if (w_coef_wr && w_addr_ok) begin
                r_coef[coef_addr] <= coef_t'(coef_data);
            end
            if (w_accept) begin
                r_ch     <= in_ch;
                r_sample <= sample_t'(in_sample);
            end
            if (r_state == LOAD) begin
                r_acc <= '0;
                r_tap <= '0;
            end else if (r_state == MAC) begin
                r_acc <= w_acc_next;
                r_tap <= r_tap + TAP_W'(1);
            end
            if (w_mac_last) begin
                r_out_valid  <= 1'b1;
                r_out_ch     <= r_ch;
                r_out_sample <= w_result;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_sample = r_out_sample;
endmodule
